// File: rtl/mul_hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op encodings, FSM states, accumulate width.
// MUL_HILO_ACC_EN makes MADD/MSUB multiply-class (accumulate into HI/LO).
package mul_hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    localparam int ACC_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
`ifdef MUL_HILO_ACC_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mul_hilo_ctrl.sv
// Sequences the external EX-stage multiplier and writes its product (or accumulation) into HI/LO.
// Optional build macro: MUL_HILO_ACC_EN enables MADD/MSUB accumulation.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO written directly from here
// RUN   | multiplier inputs held; cnt counts down to the capture cycle
module mul_hilo_ctrl
    import mul_hilo_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              mul_start,
    output logic              mul_sign,
    output logic [31:0]       mul_op1,
    output logic [31:0]       mul_op2,
    input  logic [ACC_W-1:0]  mul_result,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              done
);

    localparam logic [3:0] LAT_CNT = 4'(MUL_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  acc_op;
    logic        accept;
    logic        capture;
    logic        abort;
    logic        mt_write;
    logic [ACC_W-1:0] acc_val;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        mt_write  = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (is_mul_op(req_op)) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else if (req_op == OP_MTHI || req_op == OP_MTLO) begin
                        mt_write  = 1'b1;
                    end
                end
                stall = req_valid && is_mul_op(req_op) && !flush;
            end
            RUN: begin
                if (flush) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
                stall = (cnt != 4'd0);
            end
            default: state_nxt = IDLE;
        endcase
        // Stall must never hold the pipeline while reset is being applied.
        if (!resetn)
            stall = 1'b0;
    end

    always_comb begin
        acc_val = mul_result;
`ifdef MUL_HILO_ACC_EN
        case (acc_op)
            OP_MADD: acc_val = {hi, lo} + mul_result;
            OP_MSUB: acc_val = {hi, lo} - mul_result;
            default: acc_val = mul_result;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            acc_op    <= OP_MULT;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_start <= 1'b0;
            mul_sign  <= 1'b0;
            mul_op1   <= 32'd0;
            mul_op2   <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= capture;
            if (accept) begin
                mul_op1   <= req_a;
                mul_op2   <= req_b;
                mul_sign  <= is_signed_op(req_op);
                mul_start <= 1'b1;
                cnt       <= LAT_CNT;
                acc_op    <= req_op;
            end else if (state == RUN) begin
                if (capture || abort)
                    mul_start <= 1'b0;
                if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
            end
            if (capture && is_mul_op(acc_op))
                {hi, lo} <= acc_val;
            if (mt_write) begin
                if (req_op == OP_MTHI)
                    hi <= req_a;
                else
                    lo <= req_a;
            end
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl with a behavioural multiplier of latency LAT.
// Honours MUL_HILO_ACC_EN for the MADD/MSUB vectors.
module tb_mul_hilo_ctrl;
    import mul_hilo_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        stall, busy, mul_start, mul_sign, done;
    logic [31:0] mul_op1, mul_op2, hi, lo;
    logic [63:0] mul_result;

    int checks = 0;
    int errors = 0;
    int n_mul = 0;
    int n_accept = 0;
    int k = 0;
    logic [63:0] model = 64'd0;
    logic [63:0] sb[$];
    logic [31:0] exp_op1, exp_op2;
    logic        exp_sign;
    logic        prev_busy = 1'b0;

    mul_hilo_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall), .busy(busy),
        .mul_start(mul_start), .mul_sign(mul_sign), .mul_op1(mul_op1),
        .mul_op2(mul_op2), .mul_result(mul_result), .hi(hi), .lo(lo), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s)
            return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Multiplier: product valid LAT edges after the first edge with start high.
    always @(posedge clk) begin
        if (!mul_start) k <= 0;
        else if (k < 15) k <= k + 1;
    end
    assign mul_result = (mul_start && k >= LAT) ? prod(mul_op1, mul_op2, mul_sign)
                                                : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: done pops the scoreboard; operands must hold steady while busy.
    always @(negedge clk) begin
        if (resetn) begin
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("hilo_at_done", {hi, lo}, sb.pop_front());
            end
            if (busy) begin
                check("run_op1", {32'd0, mul_op1}, {32'd0, exp_op1});
                check("run_op2", {32'd0, mul_op2}, {32'd0, exp_op2});
                check("run_sign_start", {62'd0, mul_sign, mul_start}, {62'd0, exp_sign, 1'b1});
            end
            if (busy && !prev_busy) n_accept++;
        end
        prev_busy = busy;
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall);
        int n;
        bit is_mul;
        is_mul = (exp_stall != 0);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        if (is_mul) begin
            exp_op1 = a; exp_op2 = b;
            exp_sign = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
            if (op == OP_MADD)      model = model + prod(a, b, 1'b1);
            else if (op == OP_MSUB) model = model - prod(a, b, 1'b1);
            else                    model = prod(a, b, exp_sign);
            sb.push_back(model);
            n_mul++;
        end else if (op == OP_MTHI) begin
            model[63:32] = a;
        end else if (op == OP_MTLO) begin
            model[31:0] = a;
        end
        n = 0;
        #1;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 64'(n), 64'(exp_stall));
        @(negedge clk);
        req_valid = 1'b0;
        if (!is_mul) check("hilo_direct", {hi, lo}, model);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0;
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd9; req_b = 32'd9;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_flags", {60'd0, busy, done, mul_start, mul_sign}, 64'd0);
        check("reset_ops", {mul_op1, mul_op2}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1; req_valid = 1'b0;
        @(negedge clk);

        send(OP_MULT,  32'hFFFFFFFE, 32'h00000003, LAT + 1);
        send(OP_MULTU, 32'hFFFFFFFE, 32'h00000003, LAT + 1);
        @(negedge clk);
        send(OP_MTHI,  32'h12345678, 32'd0, 0);
        send(OP_MTLO,  32'h9ABCDEF0, 32'd0, 0);

        // Flush in IDLE beats a simultaneous request.
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd5; req_b = 32'd7; flush = 1'b1;
        #1;
        check("idle_flush_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        check("idle_flush_busy", {63'd0, busy}, 64'd0);
        flush = 1'b0;

        // MULT 5x7 flushed in the first RUN cycle.
        exp_op1 = 32'd5; exp_op2 = 32'd7; exp_sign = 1'b1;
        @(negedge clk);
        check("flush_accepted", {63'd0, busy}, 64'd1);
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_abort", {61'd0, busy, mul_start, done}, 64'd0);
        check("flush_hilo", {hi, lo}, model);
        repeat (3) @(negedge clk);
        check("flush_hilo_later", {hi, lo}, model);

        send(OP_MULT, 32'd2, 32'd3, LAT + 1);
        send(OP_MULT, 32'd4, 32'd5, LAT + 1);
        @(negedge clk);
        check("b2b_lo", {32'd0, lo}, 64'd20);

        send(OP_MTHI, 32'd0,  32'd0, 0);
        send(OP_MTLO, 32'd10, 32'd0, 0);
`ifdef MUL_HILO_ACC_EN
        send(OP_MADD, 32'd2, 32'd3, LAT + 1);
        @(negedge clk);
        check("madd_lo", {32'd0, lo}, 64'd16);
        send(OP_MSUB, 32'd4, 32'd5, LAT + 1);
        @(negedge clk);
        check("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFC);
`else
        send(OP_MADD, 32'd2, 32'd3, 0);
        check("madd_noop_lo", {32'd0, lo}, 64'd10);
        send(OP_MSUB, 32'd4, 32'd5, 0);
        check("msub_noop_hilo", {hi, lo}, 64'd10);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("accept_count", 64'(n_accept), 64'(n_mul + 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Sequencing and writeback stage wrapped around the 32x32 array multiplier in the EX stage. It accepts multiply and HI/LO-move requests from the execute pipeline and drives the multiplier's start, sign and operand inputs, holding them stable for the whole computation. It stalls the pipeline until the product is valid, then captures the 64-bit result into the architectural HI/LO registers that feed MFHI/MFLO forwarding.

## Interface
- MUL_LAT, 1: multiplier latency, in clock edges from the first edge with `mul_start` high until `mul_result` is valid. Range 1..15.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  EX holds a valid HI/LO-class instruction
- req_op  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MSUB; others no-op
- req_a, req_b  in  32  rs / rt operand values
- flush  in  1  kill the in-flight operation (exception/branch flush)
- stall  out  1  combinational; holds the pipeline while high
- busy  out  1  registered; high in RUN
- mul_start  out  1  registered multiplier enable
- mul_sign  out  1  registered; 1 for MULT/MADD/MSUB
- mul_op1, mul_op2  out  32  registered multiplier operands
- mul_result  in  64  product from the multiplier
- hi, lo  out  32  architectural HI/LO registers
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a multiply

## Operation
- FSM has two states:
  - IDLE → RUN when `req_valid`, the op is a multiply class, and `flush` is 0.
  - RUN → IDLE when `cnt==0` (the last cycle), or on `flush`.
- On accept:
  - Latch req_a/req_b into mul_op1/mul_op2.
  - Set mul_sign from op, `mul_start`=1, `cnt`=MUL_LAT, and latch the op into `acc_op`.
- RUN:
  - Operands, sign and start are held constant.
  - `cnt` decrements once per edge, saturating at 0.
- Last RUN cycle (`cnt==0`): `stall`=0, and the pipeline advances on the same edge. On that edge:
  - MULT/MULTU: {hi,lo} ← mul_result.
  - `mul_start` ← 0, and `done` ← 1.
- The request is not re-accepted while in RUN. The next request is examined in IDLE.
- MTHI/MTLO in IDLE:
  - Write hi or lo from req_a on the next edge.
  - No stall and no `done`.
- Flush:
  - In IDLE, flush wins over a simultaneous `req_valid`: nothing is accepted and HI/LO are unchanged.
  - In RUN: abort to IDLE, `mul_start` ← 0, HI/LO unchanged, no `done`.
- `stall` = (IDLE & req_valid & multiply-class op & ~flush) | (RUN & cnt≠0).
- Reset values: state IDLE, hi=lo=0, mul_start=0, mul_sign=0, mul_op1=mul_op2=0, cnt=0, done=0, busy=0. `stall` is 0 while in reset.
- A reset asserted mid-operation aborts with no HI/LO write.

## Timing
- Accept edge E0. Multiplier inputs are valid after E0.
- The result is valid after E(MUL_LAT). HI/LO are written at E(MUL_LAT+1).
- `stall` is high for MUL_LAT+1 cycles: the request cycle plus MUL_LAT RUN cycles. It is low in the final RUN cycle.
- `done` is high for exactly the cycle after E(MUL_LAT+1).
- Back-to-back multiplies:
  - The second request is seen in the IDLE cycle after capture.
  - Minimum spacing is MUL_LAT+2 cycles.
- HI/LO written by MTHI/MTLO are visible on the `hi`/`lo` ports the cycle after the edge.

## Configuration
- MUL_HILO_ACC_EN defined:
  - MADD/MSUB are multiply-class and signed.
  - At capture, {hi,lo} ← {hi,lo} ± mul_result, computed with 64-bit wrap-around arithmetic.
  - MSUB uses the two's complement of mul_result.
- Undefined: codes 100/101 are no-ops, with no stall and no state change.

## Structure
- Shared package `mul_hilo_pkg` holds:
  - the `req_op` encodings as localparams;
  - the state enum {IDLE, RUN};
  - the 64-bit accumulate width constant.
- No sub-module. The multiplier is instantiated beside this block at the EX-stage level, not inside it.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → `stall` high for 2 cycles (MUL_LAT=1), hi=0xFFFFFFFF, lo=0xFFFFFFFA, `done` pulses once.
- MULTU 0xFFFFFFFE × 0x00000003 → hi=0x00000002, lo=0xFFFFFFFA. Check that mul_op1/op2/sign are stable through all of RUN.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → no stall, hi/lo updated, `done` never high.
- MULT 5×7 with `flush` asserted in the first RUN cycle → back to IDLE, hi/lo keep their prior values, `mul_start` low next cycle, no `done`.
- Two back-to-back MULTs (2×3, then 4×5) with the pipeline holding each request under stall → each is accepted exactly once, and lo=6 then lo=20.
- With MUL_HILO_ACC_EN: preload hi=0, lo=10. MADD 2×3 → lo=16. Then MSUB 4×5 → {hi,lo}=0xFFFFFFFF_FFFFFFFC. Without the macro, the same MADD → no stall and lo stays 10.
